// File: rtl/qpmm_arbiter.sv
// qpmm_arbiter: shares one pipelined QPMM Montgomery multiplier among NREQ
// requesters. Grants round-robin, enforces the multiplier initiation interval,
// and returns each result to its issuer through an in-order tag FIFO.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/a/b   per-requester operand valid and packed operands (i at [i*W +: W])
//   req_ready       combinational one-hot grant (zero when nothing can issue)
//   mul_start/a/b   registered single-cycle issue strobe and operands
//   mul_done/z      multiplier result strobe and value (in issue order)
//   res_valid/z     registered one-hot result strobe and shared result
//   inflight        number of outstanding multiplications
//   err_underflow   sticky: mul_done seen with no outstanding tag
module qpmm_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned W            = 289,
  parameter int unsigned II           = 2,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned IDW          = $clog2(NREQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*W-1:0]               req_a,
  input  logic [NREQ*W-1:0]               req_b,
  output logic                            mul_start,
  output logic [W-1:0]                    mul_a,
  output logic [W-1:0]                    mul_b,
  input  logic                            mul_done,
  input  logic [W-1:0]                    mul_z,
  output logic [NREQ-1:0]                 res_valid,
  output logic [W-1:0]                    res_z,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_underflow
);

  localparam int unsigned CW  = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned IIW = (II > 1) ? $clog2(II) : 1;

  logic [IDW-1:0]  rr_ptr, rr_ptr_d;
  logic [IIW-1:0]  ii_cnt, ii_cnt_d;
  logic [PW-1:0]   wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0]   inflight_d;
  logic            mul_start_d, err_d;
  logic [W-1:0]    mul_a_d, mul_b_d, res_z_d;
  logic [NREQ-1:0] res_valid_d;
  logic [IDW-1:0]  tag_mem [MAX_INFLIGHT];

  logic            pop_c, push_c, can_issue_c, grant_any_c;
  logic [IDW-1:0]  grant_idx_c, cand_c;

  // Round-robin search from rr_ptr; a pop in the same cycle frees a slot.
  always_comb begin
    pop_c       = mul_done && (inflight != '0);
    can_issue_c = !rst && (ii_cnt == '0) &&
                  ((inflight < CW'(MAX_INFLIGHT)) || pop_c);
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_c = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!grant_any_c && req_valid[cand_c]) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
    push_c    = can_issue_c && grant_any_c;
    req_ready = push_c ? (NREQ'(1) << grant_idx_c) : '0;
  end

  // Next-state for issue, result return, occupancy and error tracking.
  always_comb begin
    rr_ptr_d    = rr_ptr;
    ii_cnt_d    = ii_cnt;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    inflight_d  = inflight;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a;
    mul_b_d     = mul_b;
    res_valid_d = '0;
    res_z_d     = res_z;
    err_d       = err_underflow;

    if (push_c) begin
      mul_start_d = 1'b1;
      mul_a_d     = req_a[W*32'(grant_idx_c) +: W];
      mul_b_d     = req_b[W*32'(grant_idx_c) +: W];
      rr_ptr_d    = IDW'((32'(grant_idx_c) + 1) % NREQ);
      ii_cnt_d    = IIW'(II - 1);
      wr_ptr_d    = wr_ptr + PW'(1);
    end else if (ii_cnt != '0) begin
      ii_cnt_d = ii_cnt - IIW'(1);
    end

    if (pop_c) begin
      res_valid_d = NREQ'(1) << tag_mem[rd_ptr];
      res_z_d     = mul_z;
      rd_ptr_d    = rd_ptr + PW'(1);
    end

    if (mul_done && (inflight == '0)) err_d = 1'b1;

    case ({push_c, pop_c})
      2'b10:   inflight_d = inflight + CW'(1);
      2'b01:   inflight_d = inflight - CW'(1);
      default: inflight_d = inflight;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      ii_cnt        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= '0;
      mul_start     <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      res_valid     <= '0;
      res_z         <= '0;
      err_underflow <= 1'b0;
    end else begin
      rr_ptr        <= rr_ptr_d;
      ii_cnt        <= ii_cnt_d;
      wr_ptr        <= wr_ptr_d;
      rd_ptr        <= rd_ptr_d;
      inflight      <= inflight_d;
      mul_start     <= mul_start_d;
      mul_a         <= mul_a_d;
      mul_b         <= mul_b_d;
      res_valid     <= res_valid_d;
      res_z         <= res_z_d;
      err_underflow <= err_d;
    end
  end

  // Tag storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_c) tag_mem[wr_ptr] <= grant_idx_c;
  end

endmodule

// File: tb/tb_qpmm_arbiter.sv
// Self-checking bench for qpmm_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_qpmm_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 289;
  localparam int unsigned II   = 2;
  localparam int unsigned MAXF = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic                mul_start, mul_done, err_underflow;
  logic [W-1:0]        mul_a, mul_b, mul_z, res_z;
  logic [NREQ-1:0]     res_valid;
  logic [$clog2(MAXF):0] inflight;

  always #5 clk = ~clk;

  qpmm_arbiter #(.NREQ(NREQ), .W(W), .II(II), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_z(mul_z), .res_valid(res_valid),
    .res_z(res_z), .inflight(inflight), .err_underflow(err_underflow)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: queue of owner IDs, pointer, cycle of last issue.
  int q[$];
  int rr, last_grant, tcyc, exp_grant;
  logic            m_start, m_err;
  logic [W-1:0]    m_a, m_b, m_z;
  logic [NREQ-1:0] m_rv, exp_ready;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    rr = 0; last_grant = -1000;
    m_start = 1'b0; m_a = '0; m_b = '0; m_z = '0; m_rv = '0; m_err = 1'b0;
  endtask

  // One clock: compare everything against the model, cross the edge, advance model.
  task automatic cycle();
    int g, sz0, t;
    logic elig;
    #1;
    g = -1;
    elig = !rst && ((tcyc - last_grant) >= int'(II)) &&
           ((q.size() < int'(MAXF)) || (mul_done && q.size() > 0));
    if (elig)
      for (int k = 0; k < int'(NREQ); k++) begin
        int j = (rr + k) % int'(NREQ);
        if (g < 0 && req_valid[j]) g = j;
      end
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", W'(req_ready), W'(exp_ready));
    chk("mul_start", W'(mul_start), W'(m_start));
    chk("mul_a", mul_a, m_a);
    chk("mul_b", mul_b, m_b);
    chk("res_valid", W'(res_valid), W'(m_rv));
    chk("res_z", res_z, m_z);
    chk("inflight", W'(inflight), W'(q.size()));
    chk("err_underflow", W'(err_underflow), W'(m_err));
    exp_grant = g;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      sz0 = q.size();
      if (mul_done && sz0 > 0) begin
        t = q.pop_front();
        m_rv = NREQ'(1) << t;
        m_z = mul_z;
      end else m_rv = '0;
      if (mul_done && sz0 == 0) m_err = 1'b1;
      if (g >= 0) begin
        q.push_back(g);
        m_start = 1'b1;
        m_a = req_a[g*W +: W];
        m_b = req_b[g*W +: W];
        rr = (g + 1) % int'(NREQ);
        last_grant = tcyc;
      end else m_start = 1'b0;
    end
    tcyc++;
    @(negedge clk);
  endtask

  task automatic issue(input int i);
    req_valid = NREQ'(1) << i;
    cycle();
    req_valid = '0;
    cycle();
  endtask

  int gseq[16];
  int n_grants, adj, extra;
  logic prev_start;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; mul_done = 1'b0; mul_z = '0;
    tcyc = 0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Reset state
    chk("rst_inflight", W'(inflight), W'(0));
    chk("rst_mul_start", W'(mul_start), W'(0));
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_err", W'(err_underflow), W'(0));

    // Single request
    req_a[0 +: W] = W'(3); req_b[0 +: W] = W'(5); req_valid = 4'b0001;
    #1 chk("single_ready", W'(req_ready), W'(4'b0001));
    cycle();
    req_valid = '0;
    chk("single_start", W'(mul_start), W'(1));
    chk("single_a", mul_a, W'(3));
    chk("single_b", mul_b, W'(5));
    chk("single_inflight", W'(inflight), W'(1));
    cycle();
    chk("single_start_drop", W'(mul_start), W'(0));
    chk("single_a_hold", mul_a, W'(3));
    mul_done = 1'b1; mul_z = W'('h1234);
    cycle();
    mul_done = 1'b0;
    chk("single_res_valid", W'(res_valid), W'(4'b0001));
    chk("single_res_z", res_z, W'('h1234));
    chk("single_inflight0", W'(inflight), W'(0));
    cycle();

    // Ordering 2,0,3
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[i*W +: W] = rand_w(); req_b[i*W +: W] = rand_w();
    end
    issue(2); issue(0); issue(3);
    mul_done = 1'b1;
    mul_z = W'('hA); cycle();
    chk("order_rv0", W'(res_valid), W'(4'b0100)); chk("order_z0", res_z, W'('hA));
    mul_z = W'('hB); cycle();
    chk("order_rv1", W'(res_valid), W'(4'b0001)); chk("order_z1", res_z, W'('hB));
    mul_z = W'('hC); cycle();
    chk("order_rv2", W'(res_valid), W'(4'b1000)); chk("order_z2", res_z, W'('hC));
    mul_done = 1'b0;
    cycle();
    chk("order_inflight", W'(inflight), W'(0));

    // Underflow
    mul_done = 1'b1; mul_z = W'(7);
    cycle();
    mul_done = 1'b0;
    chk("uflow_err", W'(err_underflow), W'(1));
    chk("uflow_rv", W'(res_valid), W'(0));
    chk("uflow_inflight", W'(inflight), W'(0));

    // Round-robin spacing and full FIFO
    for (int i = 0; i < int'(NREQ); i++) req_a[i*W +: W] = W'(100 + i);
    req_valid = 4'b1111;
    n_grants = 0; adj = 0; prev_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (mul_start) begin
        if (n_grants < 16) gseq[n_grants] = int'(mul_a[31:0]) - 100;
        n_grants++;
        if (prev_start) adj++;
      end
      prev_start = mul_start;
    end
    chk("full_grants", W'(n_grants), W'(8));
    chk("rr_g0", W'(gseq[0]), W'(0));
    chk("rr_g1", W'(gseq[1]), W'(1));
    chk("rr_g2", W'(gseq[2]), W'(2));
    chk("rr_g3", W'(gseq[3]), W'(3));
    chk("rr_g4", W'(gseq[4]), W'(0));
    chk("rr_adjacent", W'(adj), W'(0));
    chk("full_inflight", W'(inflight), W'(8));
    chk("full_ready", W'(req_ready), W'(0));
    mul_done = 1'b1; mul_z = W'('h55);
    #1 chk("full_pop_ready", W'(req_ready), W'(4'b0001));
    cycle();
    mul_done = 1'b0;
    chk("full_pop_start", W'(mul_start), W'(1));
    chk("full_pop_inflight", W'(inflight), W'(8));
    chk("full_pop_rv", W'(res_valid), W'(4'b0001));
    chk("full_pop_z", res_z, W'('h55));
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (mul_start) extra++;
    end
    chk("full_no_more", W'(extra), W'(0));
    chk("err_sticky", W'(err_underflow), W'(1));

    // Drain
    req_valid = '0; mul_done = 1'b1;
    for (int c = 0; c < int'(MAXF); c++) begin mul_z = rand_w(); cycle(); end
    mul_done = 1'b0;
    cycle();
    chk("drain_inflight", W'(inflight), W'(0));

    // Randomized traffic; requesters hold until granted
    for (int i = 0; i < int'(NREQ); i++) begin
      req_valid[i] = 1'($urandom);
      req_a[i*W +: W] = rand_w(); req_b[i*W +: W] = rand_w();
    end
    for (int c = 0; c < 3000; c++) begin
      mul_done = (q.size() > 0) && ($urandom_range(2) == 0);
      mul_z = rand_w();
      cycle();
      if (exp_grant >= 0) begin
        req_valid[exp_grant] = 1'($urandom);
        req_a[exp_grant*W +: W] = rand_w(); req_b[exp_grant*W +: W] = rand_w();
      end
      for (int i = 0; i < int'(NREQ); i++)
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*W +: W] = rand_w(); req_b[i*W +: W] = rand_w();
        end
    end
    req_valid = '0; mul_done = 1'b0;
    chk("err_sticky_rand", W'(err_underflow), W'(1));

    // Reset mid-flight
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      mul_done = 1'b1; mul_z = rand_w(); cycle();
    end
    mul_done = 1'b0;
    cycle(); cycle();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) cycle();
    req_valid = '0;
    cycle();
    chk("mid_inflight3", W'(inflight), W'(3));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_inflight", W'(inflight), W'(0));
    chk("mid_rst_start", W'(mul_start), W'(0));
    chk("mid_rst_a", mul_a, W'(0));
    chk("mid_rst_b", mul_b, W'(0));
    chk("mid_rst_rv", W'(res_valid), W'(0));
    chk("mid_rst_z", res_z, W'(0));
    chk("mid_rst_err", W'(err_underflow), W'(0));
    req_valid = 4'b1111;
    #1 chk("mid_rst_ptr0", W'(req_ready), W'(4'b0001));
    cycle();
    req_valid = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qpmm_arbiter.md
Name: qpmm_arbiter

Overview:
- Shares one pipelined QPMM Montgomery multiplier (BN254, 289-bit operands, K=17, N=17) among NREQ requesters, e.g. Fp2/Fp12 tower units.
- Grants requests round-robin and honours the multiplier's initiation interval.
- Tracks in-flight requester IDs in an in-order tag FIFO and routes each multiplier result back to the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 289, operand/result width (K*N of the QPMM datapath)
- II, 2, minimum cycles between consecutive mul_start pulses (>=1)
- MAX_INFLIGHT, 8, tag FIFO depth (power of 2); maximum outstanding multiplications
- IDW, $clog2(NREQ), requester ID width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*W  packed operand A; requester i at [i*W +: W]
- req_b  in  NREQ*W  packed operand B
- mul_start  out  1  single-cycle issue strobe to the multiplier
- mul_a  out  W  registered operand A to the multiplier
- mul_b  out  W  registered operand B to the multiplier
- mul_done  in  1  multiplier result valid; results return in issue order
- mul_z  in  W  multiplier result
- res_valid  out  NREQ  one-hot result strobe to the owning requester
- res_z  out  W  registered result, shared by all requesters
- inflight  out  $clog2(MAX_INFLIGHT)+1  current number of outstanding operations
- err_underflow  out  1  sticky: mul_done arrived while the tag FIFO was empty

Behaviour:
- Reset (synchronous): req_ready=0, mul_start=0, mul_a=mul_b=0, res_valid=0, res_z=0, inflight=0, err_underflow=0, round-robin pointer=0, II counter=0, tag FIFO empty.
- Issue eligibility (combinational): `can_issue = (ii_cnt==0) && (inflight < MAX_INFLIGHT || pop_this_cycle)`. A FIFO pop in the same cycle frees a slot.
- Arbitration: when can_issue, req_ready is one-hot on the first asserted req_valid, searching from rr_ptr upward and wrapping modulo NREQ. req_ready is 0 when !can_issue or no request is valid.
- Grant handshake: a transfer happens when req_valid[i] && req_ready[i]. On the next edge:
  - mul_a/mul_b latch requester i's operands and mul_start=1 for exactly one cycle (issue latency 1 cycle);
  - tag i is pushed to the FIFO;
  - rr_ptr <= (i+1) mod NREQ;
  - ii_cnt <= II-1.
- Requesters must hold req_valid and operands stable until granted.
- II counter: decrements to 0 each cycle while non-zero. With II=1 back-to-back issue every cycle is allowed.
- Result return: on mul_done with FIFO non-empty, the FIFO pops tag t. On the next edge res_valid=onehot(t) and res_z=mul_z (return latency 1 cycle). Results carry no backpressure.
- mul_done with FIFO empty: no pop, res_valid stays 0, err_underflow set to 1. err_underflow is cleared only by rst.
- inflight: +1 on push, -1 on pop, unchanged on simultaneous push and pop. It never exceeds MAX_INFLIGHT.
- Full: when inflight==MAX_INFLIGHT and there is no concurrent pop, no grant is made and the round-robin pointer is held.
- Reset mid-operation: all tags are discarded. Later mul_done pulses from the multiplier pipeline raise err_underflow; the system must reset the multiplier together with this block.
- mul_a/mul_b hold their last value when mul_start=0.

Test Plan:
- Single request: rst, then req_valid=0001 with A=3, B=5 → req_ready=0001 in that cycle, mul_start one cycle later, inflight=1. Drive mul_done with mul_z=0x1234 → res_valid=0001, res_z=0x1234 next cycle, inflight=0.
- Round-robin with II=2: req_valid=1111 held → grants in order 0,1,2,3,0 spaced 2 cycles apart; mul_start never asserted in adjacent cycles.
- Full FIFO (MAX_INFLIGHT=8, no mul_done): continuous requests → exactly 8 grants, then req_ready=0 and inflight=8. Pulse mul_done once → exactly one more grant allowed, issued in the pop cycle.
- Ordering: issue from requesters 2,0,3; return three mul_done pulses with z=0xA, 0xB, 0xC → res_valid 0100/0xA, then 0001/0xB, then 1000/0xC.
- Underflow: after reset, pulse mul_done → err_underflow=1, res_valid=0. It stays 1 through later normal traffic until rst.
- Reset mid-flight: 3 outstanding ops, assert rst for one cycle → inflight=0, all outputs 0, next request granted from pointer 0.
